uart_frame_decoder: RTL

Byte-level framing stage directly downstream of the UART receiver. Consumes the receiver's `READY` level and `DATA` byte and hunts for a start-of-frame byte. Validates length and an 8-bit additive checksum, and streams payload bytes out with an index. Signals each frame's completion as either OK (with length) or error (with code), so host command logic never sees raw serial bytes.

---
 rtl/uart_frame_pkg.sv | 18 +
 rtl/rx_byte_strobe.sv | 26 ++
 rtl/uart_frame_decoder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART framing stage.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

endpackage

// File: rtl/rx_byte_strobe.sv
// Turns the receiver's READY level into a one-cycle byte event plus its byte.
// ready_q resets high so a READY already asserted at reset release is not a byte.
module rx_byte_strobe (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] data,
  output logic       byte_ev,
  output logic [7:0] rx_byte
);

  logic ready_q;
  logic ready_d;

  always_comb ready_d = ready;

  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b1;
    else     ready_q <= ready_d;
  end

  // The receiver holds DATA stable while READY is high, so no extra capture flop.
  assign byte_ev = ready & ~ready_q;
  assign rx_byte = data;

endmodule

// File: rtl/uart_frame_decoder.sv
// Frame decoder: SOF hunt, length check, payload streaming, additive checksum,
// and inter-byte timeout. Every output is registered.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE     = DEFAULT_SOF_BYTE,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 100000
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_READY,
  input  logic [7:0] i_DATA,
  output logic       o_BYTE_VALID,
  output logic [7:0] o_BYTE,
  output logic [7:0] o_BYTE_IDX,
  output logic       o_FRAME_OK,
  output logic       o_FRAME_ERR,
  output logic [1:0] o_ERR_CODE,
  output logic [7:0] o_FRAME_LEN,
  output logic       o_BUSY
);

  localparam int               TMO_W     = $clog2(TIMEOUT_CLKS);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  logic       byte_ev;
  logic [7:0] rx_byte;

  rx_byte_strobe u_strobe (
    .clk     (i_CLK),
    .rst     (i_RST),
    .ready   (i_READY),
    .data    (i_DATA),
    .byte_ev (byte_ev),
    .rx_byte (rx_byte)
  );

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       idx_q, idx_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       byte_idx_q, byte_idx_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [7:0]       frame_len_q, frame_len_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sum_d        = sum_q;
    idx_d        = idx_q;
    tmo_cnt_d    = tmo_cnt_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    byte_idx_d   = byte_idx_q;
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    frame_len_d  = frame_len_q;

    if (state_q == ST_HUNT) begin
      tmo_cnt_d = '0;
      if (byte_ev && rx_byte == SOF_BYTE) state_d = ST_LEN;
    end else if (byte_ev) begin
      // A byte landing on the expiry cycle takes priority over the timeout.
      tmo_cnt_d = '0;
      case (state_q)
        ST_LEN: begin
          if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_HUNT;
          end else begin
            len_d   = rx_byte;
            sum_d   = rx_byte;
            idx_d   = 8'd0;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          byte_valid_d = 1'b1;
          byte_d       = rx_byte;
          byte_idx_d   = idx_q;
          sum_d        = sum_q + rx_byte;
          idx_d        = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (rx_byte == sum_q) begin
            frame_ok_d  = 1'b1;
            frame_len_d = len_q;
            err_code_d  = ERR_NONE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
          state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (tmo_cnt_q == TMO_LAST) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      tmo_cnt_d   = '0;
      state_d     = ST_HUNT;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    busy_d = (state_d != ST_HUNT);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q      <= ST_HUNT;
      len_q        <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      tmo_cnt_q    <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      byte_idx_q   <= '0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      frame_len_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      idx_q        <= idx_d;
      tmo_cnt_q    <= tmo_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      byte_idx_q   <= byte_idx_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      frame_len_q  <= frame_len_d;
      busy_q       <= busy_d;
    end
  end

  assign o_BYTE_VALID = byte_valid_q;
  assign o_BYTE       = byte_q;
  assign o_BYTE_IDX   = byte_idx_q;
  assign o_FRAME_OK   = frame_ok_q;
  assign o_FRAME_ERR  = frame_err_q;
  assign o_ERR_CODE   = err_code_q;
  assign o_FRAME_LEN  = frame_len_q;
  assign o_BUSY       = busy_q;

endmodule
